// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with registered decodes
// Optional frame counter port: define VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIX_DIV  = 1,
  parameter int CNT_W    = 10
) (
  input  logic             clock_i,
  input  logic             reset_i,
  output logic             pix_tick_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             video_on_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic [CNT_W-1:0] pixel_x_o,
  output logic [CNT_W-1:0] pixel_y_o
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int CW1     = CNT_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // One extra bit so bounds equal to 2**CNT_W still compare correctly.
  localparam logic [CNT_W:0] H_VIS_END = CW1'(H_ACTIVE);
  localparam logic [CNT_W:0] V_VIS_END = CW1'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_START  = CW1'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END    = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_START  = CW1'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END    = CW1'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             von_q, von_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;
  logic             h_wrap, v_wrap;
  logic             hs_act, vs_act;

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_d == DIV_LAST);
  end

  assign h_wrap = (x_q == H_LAST);
  assign v_wrap = (y_q == V_LAST);

  // Counters advance at the end of the cycle in which pix_tick is high.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick_q) begin
      if (h_wrap) begin
        x_d = '0;
        y_d = v_wrap ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  // Decodes evaluated on next-state so the flopped outputs line up with the counters.
  always_comb begin
    hs_act = ({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END);
    vs_act = ({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END);
    hs_d   = hs_act ? H_POL : ~H_POL;
    vs_d   = vs_act ? V_POL : ~V_POL;
    von_d  = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
    ls_d   = tick_d && (x_d == '0);
    fs_d   = ls_d && (y_d == '0);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      hs_q   <= ~H_POL;
      vs_q   <= ~V_POL;
      von_q  <= 1'b1;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_q, fc_d;

  assign fc_d = (tick_q && h_wrap && v_wrap) ? fc_q + 16'd1 : fc_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign frame_count_o = fc_q;
`endif

  assign pix_tick_o    = tick_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign video_on_o    = von_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;
  assign pixel_x_o     = x_q;
  assign pixel_y_o     = y_q;

endmodule
